// File: rtl/gemm_dsp_pkg.sv
// Shared widths, result FIFO entry type and the saturation helper for the
// GeMM column accumulator.
package gemm_dsp_pkg;

   localparam int Y_DATA_W_DEF   = 58;
   localparam int ACC_W_DEF      = 64;
   localparam int OUT_W_DEF      = 32;
   localparam int FIFO_DEPTH_DEF = 8;
   localparam int ROW_LEN_DEF    = 16;

   typedef struct packed {
      logic                        last;
      logic signed [OUT_W_DEF-1:0] data;
   } res_entry_t;

   // Clamps x to the signed range of an out_w-bit value; result stays ACC-wide.
   function automatic logic signed [ACC_W_DEF-1:0] sat_to_width(
      input logic signed [ACC_W_DEF-1:0] x,
      input int unsigned                 out_w
   );
      logic signed [ACC_W_DEF-1:0] hi;
      logic signed [ACC_W_DEF-1:0] lo;
      hi = $signed((ACC_W_DEF'(1) << (out_w - 1)) - ACC_W_DEF'(1));
      lo = ~hi;
      if (x > hi)      return hi;
      else if (x < lo) return lo;
      else             return x;
   endfunction

endpackage

// File: rtl/gemm_col_accum_if.sv
// Stream bundle between the DSP column, the accumulator and the PL writer,
// plus the status flags returned to the issue controller.
interface gemm_col_accum_if
   import gemm_dsp_pkg::*;
#(
   parameter int Y_DATA_WIDTH = Y_DATA_W_DEF,
   parameter int OUT_WIDTH    = OUT_W_DEF
);
   logic                           in_valid;
   logic signed [Y_DATA_WIDTH-1:0] in_data;
   logic                           in_last;
   logic                           out_valid;
   logic                           out_ready;
   logic signed [OUT_WIDTH-1:0]    out_data;
   logic                           out_last;
   logic                           almost_full;
   logic                           overflow;
   logic                           sat_seen;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  out_valid, out_data, out_last, almost_full, overflow, sat_seen
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output out_valid, out_data, out_last, almost_full, overflow, sat_seen
   );
endinterface

// File: rtl/gemm_res_fifo.sv
// First-word-fall-through result FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module gemm_res_fifo
   import gemm_dsp_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  res_entry_t               din_i,
   output res_entry_t               dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   res_entry_t      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gemm_col_accum.sv
// Accumulates DSP58 column partial sums across K-tiles, saturates each dot
// product to OUT_WIDTH and streams results out through a small FIFO.
module gemm_col_accum
   import gemm_dsp_pkg::*;
#(
   parameter int Y_DATA_WIDTH = Y_DATA_W_DEF,
   parameter int ACC_WIDTH    = ACC_W_DEF,
   parameter int OUT_WIDTH    = OUT_W_DEF,
   parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter int ROW_LEN      = ROW_LEN_DEF
)(
   input logic             clk,
   input logic             rst,
   gemm_col_accum_if.slave bus
);
   localparam int RC_W  = $clog2(ROW_LEN);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   if (ACC_WIDTH < Y_DATA_WIDTH || ACC_WIDTH > ACC_W_DEF || OUT_WIDTH != OUT_W_DEF)
      $error("gemm_col_accum: unsupported width combination");

   logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_base, sum;
   logic signed [ACC_W_DEF-1:0] sum_ext;
   logic                        first_q, first_d;
   logic [RC_W-1:0]             row_cnt_q, row_cnt_d;
   res_entry_t                  res_q, res_d;
   logic                        res_valid_q, res_valid_d;
   logic                        overflow_q, overflow_d;
   logic                        sat_seen_q, sat_seen_d;
   logic                        af_q, af_d;
   res_entry_t                  head;
   logic                        full, empty, pop, end_beat;
   logic [CNT_W-1:0]            count;

   assign pop      = !empty && bus.out_ready;
   assign end_beat = bus.in_valid && bus.in_last;

   always_comb begin
      acc_base    = first_q ? '0 : acc_q;
      sum         = acc_base + ACC_WIDTH'(bus.in_data);
      sum_ext     = ACC_W_DEF'(sum);
      acc_d       = acc_q;
      first_d     = first_q;
      row_cnt_d   = row_cnt_q;
      res_d       = res_q;
      res_valid_d = end_beat;
      sat_seen_d  = sat_seen_q;
      if (bus.in_valid && !bus.in_last) begin
         acc_d   = sum;
         first_d = 1'b0;
      end
      if (end_beat) begin
         first_d    = 1'b1;
         res_d.data = OUT_W_DEF'(sat_to_width(sum_ext, OUT_WIDTH));
         res_d.last = (row_cnt_q == RC_W'(ROW_LEN - 1));
         row_cnt_d  = res_d.last ? '0 : row_cnt_q + 1'b1;
         if (sat_to_width(sum_ext, OUT_WIDTH) != sum_ext) sat_seen_d = 1'b1;
      end
      // A staged result that finds the FIFO full with no pop is lost.
      overflow_d = overflow_q | (res_valid_q && full && !pop);
      af_d       = (int'(count) + int'(res_valid_q)) >= (FIFO_DEPTH - 2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         first_q     <= 1'b1;
         row_cnt_q   <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         sat_seen_q  <= 1'b0;
         af_q        <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         first_q     <= first_d;
         row_cnt_q   <= row_cnt_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         overflow_q  <= overflow_d;
         sat_seen_q  <= sat_seen_d;
         af_q        <= af_d;
      end
   end

   gemm_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (res_valid_q),
      .pop_i   (pop),
      .din_i   (res_q),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   // Head contents are masked while empty so outputs read zero after reset.
   assign bus.out_valid   = !empty;
   assign bus.out_data    = empty ? '0 : head.data;
   assign bus.out_last    = !empty && head.last;
   assign bus.almost_full = af_q;
   assign bus.overflow    = overflow_q;
   assign bus.sat_seen    = sat_seen_q;

endmodule

// File: tb/tb_gemm_col_accum.sv
// Directed-vector bench for gemm_col_accum with a queue-based scoreboard.
module tb_gemm_col_accum;
   import gemm_dsp_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gemm_col_accum_if #(.Y_DATA_WIDTH(58), .OUT_WIDTH(32)) bus ();

   gemm_col_accum dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [32:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic signed [57:0] p56;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted head is compared with the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got %0h expected none", $unsigned(bus.out_data));
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("result_data", 64'($unsigned(bus.out_data)), 64'(e[31:0]));
            check("result_last", 64'(bus.out_last), 64'(e[32]));
         end
      end
   end

   task automatic expect_res(input logic [31:0] d, input logic last);
      exp_q.push_back({last, d});
   endtask

   task automatic beat(input logic signed [57:0] d, input logic last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = '0;
      exp_q.delete();
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'($unsigned(bus.out_data)), 64'd0);
      check("rst_out_last", 64'(bus.out_last), 64'd0);
      check("rst_almost_full", 64'(bus.almost_full), 64'd0);
      check("rst_overflow", 64'(bus.overflow), 64'd0);
      check("rst_sat_seen", 64'(bus.sat_seen), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check(name, 64'(exp_q.size()), 64'd0);
      idle(2);
      check({name, "_idle"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      p56           = 58'sd1 <<< 56;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      #3;
      do_reset();

      // Multi-beat dot product and its latency.
      expect_res(32'd12, 1'b0);
      beat(58'sd5, 1'b0);
      beat(-58'sd3, 1'b0);
      beat(58'sd10, 1'b1);
      check("lat_after_e0", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("lat_after_e1", 64'(bus.out_valid), 64'd1);
      check("lat_data", 64'($unsigned(bus.out_data)), 64'd12);
      wait_drain("drain_basic");
      check("sat_seen_clear", 64'(bus.sat_seen), 64'd0);

      // Positive and negative saturation.
      do_reset();
      expect_res(32'h7FFF_FFFF, 1'b0);
      beat(p56, 1'b0);
      beat(p56, 1'b1);
      wait_drain("drain_sat_pos");
      check("sat_seen_pos", 64'(bus.sat_seen), 64'd1);
      expect_res(32'h8000_0000, 1'b0);
      beat(-p56, 1'b0);
      beat(-p56, 1'b1);
      wait_drain("drain_sat_neg");
      check("sat_seen_neg", 64'(bus.sat_seen), 64'd1);

      // Row tagging over 17 back-to-back single-beat results.
      do_reset();
      for (int v = 0; v < 17; v++) begin
         expect_res(32'(v), v == 15);
         beat(58'(v), 1'b1);
      end
      wait_drain("drain_row");

      // Fill with the consumer stalled: almost_full, drops and overflow.
      do_reset();
      bus.out_ready = 1'b0;
      for (int v = 1; v <= 10; v++) begin
         if (v <= 8) expect_res(32'(v), 1'b0);
         beat(58'(v), 1'b1);
         if (v == 6)  check("af_before", 64'(bus.almost_full), 64'd0);
         if (v == 7)  check("af_rise", 64'(bus.almost_full), 64'd1);
         if (v == 9)  check("ovf_before", 64'(bus.overflow), 64'd0);
         if (v == 10) check("ovf_set", 64'(bus.overflow), 64'd1);
      end
      idle(3);
      check("fwft_hold_data", 64'($unsigned(bus.out_data)), 64'd1);
      check("af_full", 64'(bus.almost_full), 64'd1);
      bus.out_ready = 1'b1;
      wait_drain("drain_ovf");
      check("ovf_sticky", 64'(bus.overflow), 64'd1);

      // Push and pop in the same cycle while full.
      do_reset();
      bus.out_ready = 1'b0;
      for (int v = 1; v <= 9; v++) begin
         expect_res(32'(v), 1'b0);
         beat(58'(v), 1'b1);
      end
      bus.out_ready = 1'b1;
      wait_drain("drain_fullpp");
      check("fullpp_no_ovf", 64'(bus.overflow), 64'd0);

      // Reset mid-accumulation with results queued.
      do_reset();
      bus.out_ready = 1'b0;
      for (int v = 1; v <= 3; v++) beat(58'(v), 1'b1);
      idle(2);
      check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      beat(58'sd100, 1'b0);
      beat(58'sd200, 1'b0);
      #2;
      do_reset();
      bus.out_ready = 1'b1;
      expect_res(32'd7, 1'b0);
      beat(58'sd7, 1'b1);
      wait_drain("drain_post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
